// File: rtl/secp256k1_mult_wide.sv
// 256x256 -> 512-bit unsigned multiplier for the secp256k1 datapath.
// Processes one LIMB_BITS-wide slice of b per cycle into a 512-bit accumulator.
module secp256k1_mult_wide #(
  parameter int LIMB_BITS = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [511:0] i_dat,
  input  logic         i_val,
  output logic         o_rdy,
  output logic [511:0] o_dat,
  output logic         o_val,
  input  logic         i_rdy
);

  localparam int N     = 256 / LIMB_BITS;
  localparam int K_W   = (N > 1) ? $clog2(N) : 1;
  localparam int LOG_L = $clog2(LIMB_BITS);
  localparam int PW    = 256 + LIMB_BITS;

  typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

  state_t         state_q;
  logic [K_W-1:0] k_q;
  logic [511:0]   acc_q;
  logic           rdy_q;
  logic           val_q;
  logic [255:0]   a_q;
  logic [255:0]   b_q;

  logic [PW-1:0]  prod;
  logic [8:0]     shamt;
  logic [511:0]   addend;
  logic           in_xfer;
  logic           last_limb;

  assign in_xfer   = i_val & rdy_q;
  assign last_limb = (k_q == K_W'(N - 1));

  // b_q is shifted right each MULT cycle, so its low limb is always the current slice.
  always_comb begin
    prod   = {{LIMB_BITS{1'b0}}, a_q} * {{256{1'b0}}, b_q[LIMB_BITS-1:0]};
    shamt  = 9'(k_q) << LOG_L;
    addend = 512'(prod) << shamt;
  end

  // NOTE: operand registers carry no reset; they are always loaded before use,
  // and leaving them out of the reset net keeps the wide datapath cheap.
  always_ff @(posedge i_clk) begin
    if (in_xfer) begin
      a_q <= i_dat[255:0];
      b_q <= i_dat[511:256];
    end else if (state_q == MULT) begin
      b_q <= b_q >> LIMB_BITS;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      acc_q   <= '0;
      rdy_q   <= 1'b1;
      val_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_xfer) begin
            acc_q   <= '0;
            k_q     <= '0;
            rdy_q   <= 1'b0;
            state_q <= MULT;
          end
        end
        MULT: begin
          acc_q <= acc_q + addend;
          k_q   <= k_q + K_W'(1);
          if (last_limb) begin
            val_q   <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Ready rises only after the return to IDLE, so accept never overlaps a handoff.
          if (i_rdy) begin
            val_q   <= 1'b0;
            rdy_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          val_q   <= 1'b0;
          rdy_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_dat = acc_q;
  assign o_rdy = rdy_q;
  assign o_val = val_q;

endmodule

// File: doc/secp256k1_mult_wide.md
SECP256K1_MULT_WIDE -- requirements
Module: secp256k1_mult_wide

Interface
REQ-001 The block SHALL have parameter LIMB_BITS, default 64, meaning the width of the b-operand slice processed per iteration; legal values are 16, 32, 64 and 128, each of which divides 256.
REQ-002 The block SHALL have port i_clk  input  1  single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port i_dat  input  512  operands: a = i_dat[255:0], b = i_dat[511:256], both unsigned.
REQ-005 The block SHALL have port i_val  input  1  i_dat is valid.
REQ-006 The block SHALL have port o_rdy  output  1  the block can accept an operand pair.
REQ-007 The block SHALL have port o_dat  output  512  unsigned product a*b, suitable as the 512-bit input of secp256k1_mod.
REQ-008 The block SHALL have port o_val  output  1  o_dat is valid.
REQ-009 The block SHALL have port i_rdy  input  1  the downstream block accepts o_dat.

Function
REQ-010 An input transfer SHALL occur on any rising edge where i_val=1 and o_rdy=1; an output transfer SHALL occur on any rising edge where o_val=1 and i_rdy=1.
REQ-011 The block SHALL implement the states IDLE, MULT and DONE.
REQ-012 In IDLE the block SHALL drive o_rdy=1 and o_val=0.
REQ-013 In MULT and in DONE the block SHALL drive o_rdy=0.
REQ-014 On an input transfer in IDLE, the block SHALL: register a and b; clear the 512-bit accumulator; clear the iteration counter k; enter MULT.
REQ-015 In MULT, on each edge, the block SHALL add (a * b[k*LIMB_BITS +: LIMB_BITS]) << (k*LIMB_BITS) to the accumulator, then increment k.
REQ-016 The accumulator SHALL be 512 bits wide; no carry is ever lost, because a*b < 2^512.
REQ-017 When k = N-1, where N = 256/LIMB_BITS, the block SHALL perform the final addition and enter DONE.
REQ-018 In DONE the block SHALL drive o_val=1 with o_dat equal to the accumulator.
REQ-019 o_dat SHALL remain stable while o_val=1 and i_rdy=0, for any number of cycles.
REQ-020 On an output transfer the block SHALL return to IDLE.
REQ-021 o_dat SHALL NOT be relied upon while o_val=0; it may retain its last value.
REQ-022 Latency: if an input transfer occurs on edge T, o_val SHALL first be 1 in the cycle after edge T+N (N=4 for the default parameter).
REQ-023 Throughput with i_rdy held at 1 SHALL be one product per N+2 cycles.
REQ-024 No input transfer SHALL be able to occur in the same cycle as an output transfer; o_rdy rises only in the cycle after the block returns to IDLE.
REQ-025 i_val asserted while o_rdy=0 SHALL be ignored without side effects; the upstream block holds i_dat until a transfer occurs.
REQ-026 Operand values 0, 1, p (secp256k1 p_eq) and 2^256-1 SHALL require no special-case handling.

Reset
REQ-027 While i_rst=1, on each edge the block SHALL enter IDLE, clear k, clear the accumulator and clear o_dat.
REQ-028 After reset, outputs SHALL be o_val=0 and o_rdy=1 from the first cycle after the reset edge.
REQ-029 A reset asserted during MULT or DONE SHALL abort the operation, and the aborted product SHALL never appear on o_val.
REQ-030 After reset is released, the next accepted operand pair SHALL produce a correct product with no residue from the aborted operation.

Verification
REQ-031 The bench SHALL cover: a=0, b=2^256-1 -> o_dat=0, with o_val first high in the cycle after edge T+4.
REQ-032 The bench SHALL cover: a=b=2^256-1 -> o_dat=2^512-2^257+1.
REQ-033 The bench SHALL cover: a=1<<177, b=1<<256-limb boundary value 1<<255 -> o_dat=1<<432; then feed o_dat into secp256k1_mod with expected output = (1<<432) mod p_eq.
REQ-034 The bench SHALL cover backpressure: i_rdy=0 for 20 cycles after o_val rises -> o_val stays 1, o_dat stays constant, o_rdy stays 0; i_rdy=1 -> one transfer, then o_rdy=1 on the next cycle.
REQ-035 The bench SHALL cover reset mid-operation: start a=3, b=5, assert i_rst for 1 cycle at k=2 -> no o_val; then a=7, b=11 -> o_dat=77.
REQ-036 The bench SHALL cover a random loop: 10000 random a,b pairs with random i_val/i_rdy gaps -> every o_dat equals the reference product, results arrive in order, and no operand pair is dropped or duplicated.
